// File: rtl/psk_frame_sync_pkg.sv
// Shared definitions for the PSK frame synchroniser: FSM encoding,
// default sync pattern and symbol-mode constants.
package psk_frame_sync_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_e;

    localparam logic [15:0] DEFAULT_SYNC_WORD = 16'h1ACF;

    localparam logic MODE_BPSK = 1'b0;
    localparam logic MODE_QPSK = 1'b1;

endpackage

// File: rtl/psk_byte_fifo.sv
// Synchronous FIFO for payload bytes (tlast + byte); a push while full
// only succeeds when a pop happens in the same cycle.
module psk_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_en;
    logic             rd_en;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_en    = push && (!full || pop);
        rd_en    = pop && !empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/psk_frame_sync.sv
// BPSK/QPSK frame synchroniser: hunts for the sync word, reads a length
// header, then streams the payload bytes out over AXI-Stream via a FIFO.
module psk_frame_sync
    import psk_frame_sync_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD  = DEFAULT_SYNC_WORD,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic       bpsk,
    input  logic [1:0] qpsk,
    input  logic       vld,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    output logic       m_tlast,
    input  logic       m_tready,
    output logic       locked,
    output logic       len_err,
    output logic       ovf
);

    state_e      state_q, state_d;
    logic [15:0] hist_q, hist_d;
    logic        mode_q, mode_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  len_q, len_d;
    logic        len_err_q, len_err_d;
    logic        ovf_q, ovf_d;

    logic        sym_mode;
    logic [15:0] hist_next;
    logic [2:0]  cnt_next;
    logic        byte_done;
    logic        push;
    logic [8:0]  push_data;
    logic        pop;
    logic [8:0]  pop_data;
    logic        fifo_full;
    logic        fifo_empty;

    psk_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Output fields are forced to zero when nothing is queued so the
    // uninitialised storage never reaches the port.
    assign m_tvalid = !fifo_empty;
    assign m_tdata  = fifo_empty ? 8'h00 : pop_data[7:0];
    assign m_tlast  = fifo_empty ? 1'b0 : pop_data[8];
    assign pop      = m_tvalid && m_tready;
    assign locked   = (state_q != ST_SEARCH);
    assign len_err  = len_err_q;
    assign ovf      = ovf_q;

    always_comb begin
        // The live mode pin only matters while hunting; once locked the
        // mode captured at sync governs symbol width.
        sym_mode  = (state_q == ST_SEARCH) ? mode : mode_q;
        hist_next = (sym_mode == MODE_QPSK) ? {hist_q[13:0], qpsk}
                                            : {hist_q[14:0], bpsk};
        cnt_next  = cnt_q + ((sym_mode == MODE_QPSK) ? 3'd2 : 3'd1);
        byte_done = (cnt_next == 3'd0);

        state_d   = state_q;
        hist_d    = hist_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        len_err_d = 1'b0;
        push      = 1'b0;
        push_data = {(len_q == 8'd1), hist_next[7:0]};

        if (vld) begin
            unique case (state_q)
                ST_SEARCH: begin
                    hist_d = hist_next;
                    if (hist_next == SYNC_WORD) begin
                        state_d = ST_HEADER;
                        mode_d  = mode;
                        cnt_d   = 3'd0;
                    end
                end
                ST_HEADER: begin
                    hist_d = hist_next;
                    cnt_d  = cnt_next;
                    if (byte_done) begin
                        if (hist_next[7:0] == 8'd0) begin
                            len_err_d = 1'b1;
                            state_d   = ST_SEARCH;
                            hist_d    = '0;
                        end else begin
                            len_d   = hist_next[7:0];
                            state_d = ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    hist_d = hist_next;
                    cnt_d  = cnt_next;
                    if (byte_done) begin
                        // The count advances even if the FIFO drops the byte,
                        // so the frame always ends on schedule.
                        push  = 1'b1;
                        len_d = len_q - 8'd1;
                        if (len_q == 8'd1) begin
                            state_d = ST_SEARCH;
                            hist_d  = '0;
                        end
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end

        ovf_d = ovf_q || (push && fifo_full && !pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_SEARCH;
            hist_q    <= '0;
            mode_q    <= MODE_BPSK;
            cnt_q     <= '0;
            len_q     <= '0;
            len_err_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            len_err_q <= len_err_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_psk_frame_sync.sv
// Directed bench for psk_frame_sync: table of byte-level vectors plus
// hand-written sequences for length error, overflow and mid-frame reset.
module tb_psk_frame_sync;

    logic       clk;
    logic       rst;
    logic       mode;
    logic       bpsk;
    logic [1:0] qpsk;
    logic       vld;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tlast;
    logic       m_tready;
    logic       locked;
    logic       len_err;
    logic       ovf;

    int n_checks = 0;
    int n_fail   = 0;

    psk_frame_sync #(
        .SYNC_WORD  (16'h1ACF),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .bpsk     (bpsk),
        .qpsk     (qpsk),
        .vld      (vld),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tready (m_tready),
        .locked   (locked),
        .len_err  (len_err),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       mode;
        logic [7:0] din;
        logic       ev;
        logic [7:0] ed;
        logic       el;
        logic       elk;
    } vec_t;

    vec_t tbl [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic pin_mode, input logic b, input logic [1:0] q);
        mode = pin_mode;
        bpsk = b;
        qpsk = q;
        vld  = 1'b1;
        step();
        vld  = 1'b0;
    endtask

    // Sends one byte MSB first; optionally checks that no output byte is
    // pending just before the byte completes.
    task automatic send_byte(input logic sym_mode, input logic pin_mode,
                             input logic [7:0] data, input logic chk_mid);
        if (sym_mode) begin
            for (int i = 3; i >= 0; i--) begin
                send_sym(pin_mode, 1'b0, data[2*i +: 2]);
                if (chk_mid && i == 1) check("mid_tvalid_q", 32'(m_tvalid), 32'd0);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                send_sym(pin_mode, data[i], 2'b00);
                if (chk_mid && i == 1) check("mid_tvalid_b", 32'(m_tvalid), 32'd0);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        mode     = 1'b0;
        bpsk     = 1'b0;
        qpsk     = 2'b00;
        vld      = 1'b0;
        m_tready = 1'b1;

        //           mode  din     ev    ed     el    elk
        tbl[0]  = '{1'b0, 8'h1A, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 8'hCF, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 8'h02, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 8'hA5, 1'b1, 8'hA5, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 8'h1A, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 8'hCF, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 8'h02, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 8'hA5, 1'b1, 8'hA5, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 8'h1A, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 8'hCF, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 8'h03, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 8'h1A, 1'b1, 8'h1A, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 8'hCF, 1'b1, 8'hCF, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 8'h77, 1'b1, 8'h77, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 8'h1A, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 8'hCF, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 8'h55, 1'b1, 8'h55, 1'b1, 1'b0};

        step();
        step();
        rst = 1'b0;
        check("rst_tvalid",  32'(m_tvalid), 32'd0);
        check("rst_tlast",   32'(m_tlast),  32'd0);
        check("rst_tdata",   32'(m_tdata),  32'd0);
        check("rst_locked",  32'(locked),   32'd0);
        check("rst_len_err", 32'(len_err),  32'd0);
        check("rst_ovf",     32'(ovf),      32'd0);

        // Table: BPSK frame, QPSK frame, payload with embedded sync + next frame
        for (int r = 0; r < 20; r++) begin
            send_byte(tbl[r].mode, tbl[r].mode, tbl[r].din, 1'b1);
            check($sformatf("tbl%0d_tvalid", r), 32'(m_tvalid), 32'(tbl[r].ev));
            check($sformatf("tbl%0d_locked", r), 32'(locked),   32'(tbl[r].elk));
            if (tbl[r].ev) begin
                check($sformatf("tbl%0d_tdata", r), 32'(m_tdata), 32'(tbl[r].ed));
                check($sformatf("tbl%0d_tlast", r), 32'(m_tlast), 32'(tbl[r].el));
            end
        end
        step();
        check("tbl_drained", 32'(m_tvalid), 32'd0);

        // Zero-length header
        send_byte(1'b0, 1'b0, 8'h1A, 1'b0);
        send_byte(1'b0, 1'b0, 8'hCF, 1'b0);
        check("lerr_locked_hdr", 32'(locked), 32'd1);
        send_byte(1'b0, 1'b0, 8'h00, 1'b0);
        check("lerr_pulse",  32'(len_err),  32'd1);
        check("lerr_locked", 32'(locked),   32'd0);
        check("lerr_tvalid", 32'(m_tvalid), 32'd0);
        step();
        check("lerr_single", 32'(len_err),  32'd0);
        check("lerr_tvalid2", 32'(m_tvalid), 32'd0);

        // Overflow: L=6, ready low, depth 4
        m_tready = 1'b0;
        send_byte(1'b0, 1'b0, 8'h1A, 1'b0);
        send_byte(1'b0, 1'b0, 8'hCF, 1'b0);
        send_byte(1'b0, 1'b0, 8'h06, 1'b0);
        send_byte(1'b0, 1'b0, 8'h11, 1'b0);
        send_byte(1'b0, 1'b0, 8'h22, 1'b0);
        send_byte(1'b0, 1'b0, 8'h33, 1'b0);
        send_byte(1'b0, 1'b0, 8'h44, 1'b0);
        check("ovf_full_noflag", 32'(ovf),     32'd0);
        check("ovf_hold_data1",  32'(m_tdata), 32'h11);
        send_byte(1'b0, 1'b0, 8'h55, 1'b0);
        check("ovf_flag",        32'(ovf),     32'd1);
        check("ovf_hold_data2",  32'(m_tdata), 32'h11);
        send_byte(1'b0, 1'b0, 8'h66, 1'b0);
        check("ovf_locked_end",  32'(locked),  32'd0);
        check("ovf_hold_data3",  32'(m_tdata), 32'h11);
        check("ovf_hold_last",   32'(m_tlast), 32'd0);
        step();
        check("ovf_sticky",      32'(ovf),     32'd1);
        m_tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain%0d_tvalid", k), 32'(m_tvalid), 32'd1);
            check($sformatf("drain%0d_tdata", k),  32'(m_tdata),  32'(8'h11 * (k + 1)));
            check($sformatf("drain%0d_tlast", k),  32'(m_tlast),  32'd0);
            step();
        end
        check("drain_empty", 32'(m_tvalid), 32'd0);

        // Reset mid-payload with a byte queued and a partial byte in flight
        m_tready = 1'b0;
        send_byte(1'b0, 1'b0, 8'h1A, 1'b0);
        send_byte(1'b0, 1'b0, 8'hCF, 1'b0);
        send_byte(1'b0, 1'b0, 8'h03, 1'b0);
        send_byte(1'b0, 1'b0, 8'hAA, 1'b0);
        for (int i = 0; i < 4; i++) send_sym(1'b0, 1'b1, 2'b00);
        check("pre_rst_tvalid", 32'(m_tvalid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_tvalid", 32'(m_tvalid), 32'd0);
        check("mrst_tdata",  32'(m_tdata),  32'd0);
        check("mrst_tlast",  32'(m_tlast),  32'd0);
        check("mrst_locked", 32'(locked),   32'd0);
        check("mrst_ovf",    32'(ovf),      32'd0);
        check("mrst_len_err", 32'(len_err), 32'd0);

        // Fresh QPSK frame; mode pin dropped to BPSK while locked must be ignored
        m_tready = 1'b1;
        send_byte(1'b1, 1'b1, 8'h1A, 1'b1);
        send_byte(1'b1, 1'b1, 8'hCF, 1'b1);
        check("post_locked", 32'(locked), 32'd1);
        send_byte(1'b1, 1'b0, 8'h01, 1'b1);
        send_byte(1'b1, 1'b0, 8'hC3, 1'b1);
        check("post_tvalid", 32'(m_tvalid), 32'd1);
        check("post_tdata",  32'(m_tdata),  32'hC3);
        check("post_tlast",  32'(m_tlast),  32'd1);
        check("post_locked_end", 32'(locked), 32'd0);
        step();
        check("post_drained", 32'(m_tvalid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
